module_mux_arb_n_1: RTL and testbench
=====================================

Name: module_mux_arb_n_1

Overview:
- Parametrised N-channel successor to the UART 2:1 data mux.
- Merges N producer streams, each with its own valid/ready handshake, into one registered output stream.
- Selects between channels by round-robin or fixed-priority arbitration.
- Used in the UART peripheral so the CPU store path, the test-pattern generator and future DMA can share one TX data path without combinational select glue.

Parameters:
- ANCHO, 32: data width in bits per channel.
- N_CANALES, 4: number of input channels, ≥2.
- MODO, 0: 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous reset, active-high.
- dato_i  input  N_CANALES*ANCHO  flattened channel data; channel k occupies bits [k*ANCHO +: ANCHO].
- valido_i  input  N_CANALES  per-channel data valid.
- listo_o  output  N_CANALES  per-channel ready; one-hot or zero.
- dato_o  output  ANCHO  registered output data.
- valido_o  output  1  output valid.
- listo_i  input  1  downstream ready.
- canal_o  output  $clog2(N_CANALES)  index of the channel that produced the current dato_o.

Behaviour:
- Reset (async assert, sync-safe deassert by upstream):
  - dato_o=0, valido_o=0, canal_o=0.
  - Round-robin pointer = N_CANALES-1, so channel 0 has first priority after reset.
  - listo_o=0 while rst_i is high.
- Output register states:
  - VACIO: valido_o=0.
  - LLENO: valido_o=1.
- carga = (valido_o==0) || listo_i. The register can accept new data this cycle.
- Grant is combinational from valido_i and the pointer:
  - MODO=0: first requesting channel searching from pointer+1 upward, wrapping modulo N_CANALES.
  - MODO=1: lowest-index requesting channel.
- listo_o[g] = carga && (some valido_i set), where g is the granted index; all other listo_o bits are 0.
  - listo_o never depends on valido_i of a non-granted channel being low.
- Transfer on channel g happens when valido_i[g] && listo_o[g]. On that clock edge:
  - dato_o <= dato_i[g]
  - canal_o <= g
  - valido_o <= 1
  - pointer <= g (MODO=0 only)
- Output transfer happens when valido_o && listo_i. If no input transfer occurs on the same edge, valido_o <= 0.
  - dato_o and canal_o hold their last values.
- Simultaneous output transfer and input transfer: the register reloads, valido_o stays 1. Full throughput is one word per cycle.
- Latency: input transfer to valido_o high is 1 cycle.
- While LLENO and listo_i=0:
  - dato_o, canal_o and valido_o are stable.
  - All listo_o are 0.
  - The pointer is frozen.
- Requester drops valido_i before a grant: no transfer and no state change. Producers must hold data stable while valido_i is high.
- Single requester: always granted when carga=1, in both modes.
- Pointer wrap: pointer=N_CANALES-1 searches 0,1,… in order.
- Reset mid-transfer: any word in flight is discarded, with no partial output.

Decomposition:
- Package mux_arb_pkg:
  - enum modo_arb_t {ARB_ROUND_ROBIN=0, ARB_PRIORIDAD_FIJA=1}.
  - Function calc_ancho_idx(n) returning max(1,$clog2(n)).
- Sub-module module_arbitro_rr (parameters N_CANALES, MODO):
  - Inputs: clk_i, rst_i, solicitud_i[N], habilita_i (=carga).
  - Outputs: concesion_o one-hot, indice_o.
  - Holds the pointer and updates it on habilita_i && |solicitud_i.
- Top level holds the output register and data select, implemented as an indexed part-select, not a chain of 2:1 muxes.

Test Plan (N_CANALES=4, ANCHO=32):
- Reset released, valido_i=4'b0000 for 5 cycles → valido_o=0, listo_o=0, dato_o=0.
- MODO=0:
  - Setup: valido_i=4'b1111, data 0xA0..0xA3, listo_i=1 constant.
  - Required response:
    - canal_o sequence 0,1,2,3,0 on consecutive cycles.
    - dato_o 0xA0,0xA1,0xA2,0xA3,0xA0.
    - valido_o continuously 1.
- MODO=1:
  - Setup: valido_i=4'b1010, listo_i=1.
  - Required response: every grant goes to channel 1, channel 3 is starved, listo_o=4'b0010.
- Backpressure:
  - Setup: load 0x55 from channel 2, then listo_i=0 for 3 cycles while valido_i=4'b1111.
  - Required response:
    - dato_o=0x55 held, listo_o=0 throughout.
    - After listo_i=1, next grant goes to channel 3, then the round-robin sequence resumes.
- Single channel 3 requesting with pointer=3 → granted next cycle, dato_o=dato of ch3, valido_o=1 after 1 cycle.
- Assert rst_i asynchronously mid-stream (between edges) with valido_o=1 → valido_o, dato_o and listo_o go 0 immediately; after release the first grant goes to channel 0.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the N-channel merging multiplexer.
package mux_arb_pkg;

   // Arbitration policy selected by the MODO parameter.
   typedef enum logic {
      ARB_ROUND_ROBIN    = 1'b0,
      ARB_PRIORIDAD_FIJA = 1'b1
   } modo_arb_t;

   // Occupancy of the single output register.
   typedef enum logic {
      VACIO = 1'b0,
      LLENO = 1'b1
   } estado_t;

   // Index width for n channels, never less than one bit.
   function automatic int calc_ancho_idx(input int n);
      int w;
      w = $clog2(n);
      if (w < 1) begin
         return 1;
      end else begin
         return w;
      end
   endfunction

endpackage

// File: rtl/module_arbitro_rr.sv
// Channel arbiter: round-robin search from the last winner or fixed
// lowest-index priority. The grant is purely combinational; only the
// round-robin pointer is stored.
module module_arbitro_rr
   import mux_arb_pkg::*;
#(
   parameter int N_CANALES = 4,
   parameter int MODO      = 0,
   localparam int IW       = calc_ancho_idx(N_CANALES)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [N_CANALES-1:0] solicitud_i,
   input  logic                 habilita_i,
   output logic [N_CANALES-1:0] concesion_o,
   output logic [IW-1:0]        indice_o
);

   logic [IW-1:0]        puntero_q;
   logic [IW-1:0]        puntero_d;
   logic [N_CANALES-1:0] concesion_s;
   logic [IW-1:0]        indice_s;
   logic [IW-1:0]        cand_s;
   logic                 hallado_s;

   // Pick the first requester in search order (pointer+1 upward, or index 0 upward).
   always_comb begin
      concesion_s = '0;
      indice_s    = '0;
      cand_s      = '0;
      hallado_s   = 1'b0;
      for (int i = 0; i < N_CANALES; i++) begin
         if (MODO == int'(ARB_PRIORIDAD_FIJA)) begin
            cand_s = IW'(i);
         end else begin
            cand_s = IW'((int'(puntero_q) + 1 + i) % N_CANALES);
         end
         if (!hallado_s && solicitud_i[cand_s]) begin
            hallado_s           = 1'b1;
            indice_s            = cand_s;
            concesion_s[cand_s] = 1'b1;
         end else begin
            hallado_s = hallado_s;
         end
      end
   end

   // Remember the winner of an accepted round-robin grant; otherwise hold.
   always_comb begin
      puntero_d = puntero_q;
      if ((MODO == int'(ARB_ROUND_ROBIN)) && habilita_i && (|solicitud_i)) begin
         puntero_d = indice_s;
      end else begin
         puntero_d = puntero_q;
      end
   end

   // Pointer register; reset to the last channel so channel 0 is searched first.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         puntero_q <= IW'(N_CANALES - 1);
      end else begin
         puntero_q <= puntero_d;
      end
   end

   assign concesion_o = concesion_s;
   assign indice_o    = indice_s;

endmodule

// File: rtl/module_mux_arb_n_1.sv
// N-to-1 stream merger: arbitrates among valid/ready producers and loads
// the winning word into a single registered output stage.
module module_mux_arb_n_1
   import mux_arb_pkg::*;
#(
   parameter int ANCHO     = 32,
   parameter int N_CANALES = 4,
   parameter int MODO      = 0,
   localparam int IW       = calc_ancho_idx(N_CANALES)
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [N_CANALES*ANCHO-1:0] dato_i,
   input  logic [N_CANALES-1:0]       valido_i,
   output logic [N_CANALES-1:0]       listo_o,
   output logic [ANCHO-1:0]           dato_o,
   output logic                       valido_o,
   input  logic                       listo_i,
   output logic [IW-1:0]              canal_o
);

   estado_t              estado_q;
   estado_t              estado_d;
   logic [ANCHO-1:0]     dato_q;
   logic [ANCHO-1:0]     dato_d;
   logic [IW-1:0]        canal_q;
   logic [IW-1:0]        canal_d;
   logic                 carga_s;
   logic                 entrada_s;
   logic [N_CANALES-1:0] concesion_s;
   logic [IW-1:0]        indice_s;

   // Register may take a word when empty or when its word leaves this cycle.
   assign carga_s   = (estado_q == VACIO) || listo_i;
   assign entrada_s = carga_s && (|valido_i);
   assign listo_o   = (entrada_s && !rst_i) ? concesion_s : '0;

   module_arbitro_rr #(
      .N_CANALES (N_CANALES),
      .MODO      (MODO)
   ) u_arbitro (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .solicitud_i (valido_i),
      .habilita_i  (carga_s),
      .concesion_o (concesion_s),
      .indice_o    (indice_s)
   );

   // Next state of the output stage: load on input transfer, drain on output transfer.
   always_comb begin
      estado_d = estado_q;
      dato_d   = dato_q;
      canal_d  = canal_q;
      if (entrada_s) begin
         estado_d = LLENO;
         dato_d   = dato_i[int'(indice_s)*ANCHO +: ANCHO];
         canal_d  = indice_s;
      end else begin
         case (estado_q)
            LLENO: begin
               if (listo_i) begin
                  estado_d = VACIO;
               end else begin
                  estado_d = LLENO;
               end
            end
            VACIO:   estado_d = VACIO;
            default: estado_d = VACIO;
         endcase
      end
   end

   // Output stage registers; reset discards any word in flight.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         estado_q <= VACIO;
         dato_q   <= '0;
         canal_q  <= '0;
      end else begin
         estado_q <= estado_d;
         dato_q   <= dato_d;
         canal_q  <= canal_d;
      end
   end

   assign dato_o   = dato_q;
   assign canal_o  = canal_q;
   assign valido_o = (estado_q == LLENO);

endmodule

// File: tb/tb_module_mux_arb_n_1.sv
// Bench for the N-to-1 merger: a round-robin and a fixed-priority instance
// share stimulus; both are compared every cycle against a behavioural model,
// and a table plus hand sequences pin down the documented scenarios.
module tb_module_mux_arb_n_1;

   localparam int N = 4;
   localparam int W = 32;

   logic           clk_i = 1'b0;
   logic           rst_i;
   logic [N*W-1:0] dato_i;
   logic [N-1:0]   valido_i;
   logic           listo_i;

   logic [N-1:0] listo_rr, listo_fp;
   logic [W-1:0] dato_rr, dato_fp;
   logic         valido_rr, valido_fp;
   logic [1:0]   canal_rr, canal_fp;

   always #5 clk_i = ~clk_i;

   module_mux_arb_n_1 #(.ANCHO(W), .N_CANALES(N), .MODO(0)) dut_rr (
      .clk_i(clk_i), .rst_i(rst_i), .dato_i(dato_i), .valido_i(valido_i),
      .listo_o(listo_rr), .dato_o(dato_rr), .valido_o(valido_rr),
      .listo_i(listo_i), .canal_o(canal_rr)
   );

   module_mux_arb_n_1 #(.ANCHO(W), .N_CANALES(N), .MODO(1)) dut_fp (
      .clk_i(clk_i), .rst_i(rst_i), .dato_i(dato_i), .valido_i(valido_i),
      .listo_o(listo_fp), .dato_o(dato_fp), .valido_o(valido_fp),
      .listo_i(listo_i), .canal_o(canal_fp)
   );

   int total = 0;
   int bad   = 0;

   logic [W-1:0] ch_dat [N];
   bit           m_full [2];
   logic [W-1:0] m_dat  [2];
   int           m_ch   [2];
   int           m_ptr  [2];
   logic [N-1:0] last_listo [2];

   typedef struct {
      logic [3:0]  val;
      logic        lis;
      int          sel;
      logic [3:0]  e_listo;
      logic        e_val;
      logic [31:0] e_dato;
      int          e_canal;
   } vec_t;

   vec_t tabla[$];

   task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nombre, act, exp);
      end
   endtask

   // Winner by the arbitration rules: -1 when nobody asks.
   function automatic int ganador(input int modo, input int ptr, input logic [3:0] req);
      if (req == 4'd0) return -1;
      if (modo == 1) begin
         for (int k = 0; k < N; k++) if (req[k]) return k;
      end else begin
         for (int k = 1; k <= N; k++) if (req[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         m_full[m] = 1'b0;
         m_dat[m]  = 32'd0;
         m_ch[m]   = 0;
         m_ptr[m]  = N - 1;
      end
   endtask

   task automatic pack();
      for (int k = 0; k < N; k++) dato_i[k*W +: W] = ch_dat[k];
   endtask

   // One clock: drive, check ready lines, advance model, check registered outputs.
   task automatic ciclo(input logic [3:0] val, input logic lis);
      int g;
      bit carga;
      logic [3:0] exp_l;
      valido_i = val;
      listo_i  = lis;
      pack();
      #1;
      last_listo[0] = listo_rr;
      last_listo[1] = listo_fp;
      for (int m = 0; m < 2; m++) begin
         carga = !m_full[m] || lis;
         g     = ganador(m, m_ptr[m], val);
         exp_l = (carga && g >= 0) ? 4'(1 << g) : 4'd0;
         chk($sformatf("listo_m%0d", m), {28'd0, last_listo[m]}, {28'd0, exp_l});
         if (carga && g >= 0) begin
            m_full[m] = 1'b1;
            m_dat[m]  = ch_dat[g];
            m_ch[m]   = g;
            if (m == 0) m_ptr[m] = g;
         end else if (m_full[m] && lis) begin
            m_full[m] = 1'b0;
         end
      end
      @(posedge clk_i);
      #1;
      chk("valido_rr", {31'd0, valido_rr}, {31'd0, m_full[0]});
      chk("dato_rr", dato_rr, m_dat[0]);
      chk("canal_rr", {30'd0, canal_rr}, 32'(m_ch[0]));
      chk("valido_fp", {31'd0, valido_fp}, {31'd0, m_full[1]});
      chk("dato_fp", dato_fp, m_dat[1]);
      chk("canal_fp", {30'd0, canal_fp}, 32'(m_ch[1]));
   endtask

   task automatic hard_reset();
      rst_i = 1'b1;
      #1;
      model_reset();
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
   endtask

   task automatic default_data();
      ch_dat[0] = 32'hA0; ch_dat[1] = 32'hA1; ch_dat[2] = 32'hA2; ch_dat[3] = 32'hA3;
   endtask

   initial begin
      rst_i    = 1'b0;
      valido_i = 4'b1111;
      listo_i  = 1'b0;
      default_data();
      pack();
      #1 rst_i = 1'b1;
      #1;
      chk("rst_valido", {31'd0, valido_rr}, 32'd0);
      chk("rst_dato", dato_rr, 32'd0);
      chk("rst_canal", {30'd0, canal_rr}, 32'd0);
      chk("rst_listo", {28'd0, listo_rr}, 32'd0);
      model_reset();
      @(posedge clk_i);
      @(posedge clk_i);
      #1 rst_i = 1'b0;

      for (int i = 0; i < 5; i++) tabla.push_back('{4'b0000, 1'b1, 0, 4'b0000, 1'b0, 32'h0, 0});
      tabla.push_back('{4'b1111, 1'b1, 0, 4'b0001, 1'b1, 32'hA0, 0});
      tabla.push_back('{4'b1111, 1'b1, 0, 4'b0010, 1'b1, 32'hA1, 1});
      tabla.push_back('{4'b1111, 1'b1, 0, 4'b0100, 1'b1, 32'hA2, 2});
      tabla.push_back('{4'b1111, 1'b1, 0, 4'b1000, 1'b1, 32'hA3, 3});
      tabla.push_back('{4'b1111, 1'b1, 0, 4'b0001, 1'b1, 32'hA0, 0});
      for (int i = 0; i < 3; i++) tabla.push_back('{4'b1010, 1'b1, 1, 4'b0010, 1'b1, 32'hA1, 1});

      foreach (tabla[i]) begin
         ciclo(tabla[i].val, tabla[i].lis);
         chk($sformatf("tab%0d_listo", i), {28'd0, last_listo[tabla[i].sel]}, {28'd0, tabla[i].e_listo});
         if (tabla[i].sel == 0) begin
            chk($sformatf("tab%0d_valido", i), {31'd0, valido_rr}, {31'd0, tabla[i].e_val});
            chk($sformatf("tab%0d_dato", i), dato_rr, tabla[i].e_dato);
            chk($sformatf("tab%0d_canal", i), {30'd0, canal_rr}, 32'(tabla[i].e_canal));
         end else begin
            chk($sformatf("tab%0d_valido", i), {31'd0, valido_fp}, {31'd0, tabla[i].e_val});
            chk($sformatf("tab%0d_dato", i), dato_fp, tabla[i].e_dato);
            chk($sformatf("tab%0d_canal", i), {30'd0, canal_fp}, 32'(tabla[i].e_canal));
         end
      end

      // Backpressure: hold 0x55 from channel 2, then resume at channel 3.
      hard_reset();
      ch_dat[2] = 32'h55;
      ciclo(4'b0100, 1'b1);
      chk("bp_load_dato", dato_rr, 32'h55);
      chk("bp_load_canal", {30'd0, canal_rr}, 32'd2);
      for (int i = 0; i < 3; i++) begin
         ciclo(4'b1111, 1'b0);
         chk("bp_hold_listo", {28'd0, last_listo[0]}, 32'd0);
         chk("bp_hold_dato", dato_rr, 32'h55);
         chk("bp_hold_valido", {31'd0, valido_rr}, 32'd1);
      end
      ciclo(4'b1111, 1'b1);
      chk("bp_resume_listo", {28'd0, last_listo[0]}, 32'h8);
      chk("bp_resume_canal", {30'd0, canal_rr}, 32'd3);
      ciclo(4'b1111, 1'b1);
      chk("bp_seq_canal0", {30'd0, canal_rr}, 32'd0);
      ciclo(4'b1111, 1'b1);
      chk("bp_seq_canal1", {30'd0, canal_rr}, 32'd1);

      // Single requester on channel 3 with the pointer already at 3.
      default_data();
      hard_reset();
      ciclo(4'b1000, 1'b1);
      chk("solo3_listo", {28'd0, last_listo[0]}, 32'h8);
      chk("solo3_dato", dato_rr, 32'hA3);
      chk("solo3_valido", {31'd0, valido_rr}, 32'd1);
      ciclo(4'b1000, 1'b1);
      chk("solo3_again_canal", {30'd0, canal_rr}, 32'd3);

      // Asynchronous reset between edges while the output is full.
      valido_i = 4'b1111;
      #2 rst_i = 1'b1;
      #1;
      chk("arst_valido", {31'd0, valido_rr}, 32'd0);
      chk("arst_dato", dato_rr, 32'd0);
      chk("arst_listo", {28'd0, listo_rr}, 32'd0);
      chk("arst_valido_fp", {31'd0, valido_fp}, 32'd0);
      model_reset();
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      ciclo(4'b1111, 1'b1);
      chk("arst_first_listo", {28'd0, last_listo[0]}, 32'h1);
      chk("arst_first_canal", {30'd0, canal_rr}, 32'd0);
      chk("arst_first_dato", dato_rr, 32'hA0);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         for (int k = 0; k < N; k++) ch_dat[k] = $urandom;
         if (i == 200) begin
            #2 rst_i = 1'b1;
            #1;
            chk("rnd_arst_valido", {31'd0, valido_rr}, 32'd0);
            model_reset();
            @(posedge clk_i);
            #1 rst_i = 1'b0;
         end
         ciclo(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
